uctl_cmdif_decode: RTL

UCTL_CMDIF_DECODE -- requirements
Module: uctl_cmdif_decode

---
 rtl/uctl_pkg.sv | 31 +++
 rtl/uctl_cmdif_decode.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uctl_pkg.sv
// rtl/uctl_pkg.sv - shared FSM state, region codes and timeout default for the command interface decoder
package uctl_pkg;

  localparam logic [7:0] TMO_MAX_DEFAULT = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_REG_BEAT   = 3'd2,
    ST_MEM_REQ    = 3'd3,
    ST_MEM_RDWAIT = 3'd4,
    ST_ACK        = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RGN_REG      = 2'd0,
    RGN_MEM      = 2'd1,
    RGN_UNMAPPED = 2'd2
  } region_e;

  // Upper address bits pick the target: page 0 is the register bank, page 1 the buffer.
  function automatic region_e decode_region(input logic [19:0] addr_hi);
    if (addr_hi == 20'd0)
      return RGN_REG;
    else if (addr_hi == 20'd1)
      return RGN_MEM;
    else
      return RGN_UNMAPPED;
  endfunction

endpackage

// File: rtl/uctl_cmdif_decode.sv
// rtl/uctl_cmdif_decode.sv - command interface decoder routing data beats to register bank or buffer
module uctl_cmdif_decode
  import uctl_pkg::*;
#(
  parameter logic [7:0] TMO_MAX = TMO_MAX_DEFAULT
) (
  input  logic        hClk,
  input  logic        hReset_n,
  input  logic        swRst,
  input  logic        cmdIf_trEn,
  input  logic        cmdIf_req,
  input  logic        cmdIf_wrRd,
  input  logic [31:0] cmdIf_addr,
  output logic        cmdIf_ack,
  input  logic        cmdIf_wrData_req,
  input  logic [31:0] cmdIf_wrData,
  output logic        cmdIf_wrData_ack,
  input  logic        cmdIf_rdData_req,
  output logic [31:0] cmdIf_rdData,
  output logic        cmdIf_rdData_ack,
  output logic        reg_wrEn,
  output logic        reg_rdEn,
  output logic [9:0]  reg_addr,
  output logic [31:0] reg_wrData,
  input  logic [31:0] reg_rdData,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wrData,
  input  logic        mem_gnt,
  input  logic        mem_rdVld,
  input  logic [31:0] mem_rdData,
  output logic        err_unmapped,
  output logic        err_tmo
);

  // All state and registered outputs live in one struct so both resets clear it in one go.
  typedef struct packed {
    state_e      state;
    region_e     region;
    logic        wr;
    logic [9:0]  waddr;
    logic        drain;
    logic [7:0]  cnt;
    logic        cmd_ack;
    logic        wr_ack;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic        mem_req;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic        err_unmapped;
    logic        err_tmo;
  } ctl_t;

  ctl_t        r;
  logic        beat_req;
  logic        drain_now;
  logic [7:0]  cnt_inc;
  logic [9:0]  waddr_inc;
  logic        unused_addr_lsb;

  // Only the data request matching the latched direction counts as a beat.
  assign beat_req        = r.wr ? cmdIf_wrData_req : cmdIf_rdData_req;
  assign drain_now       = r.drain | ~cmdIf_trEn;
  assign cnt_inc         = r.cnt + 8'd1;
  assign waddr_inc       = r.waddr + 10'd1;
  assign unused_addr_lsb = ^cmdIf_addr[1:0];

  // Command FSM with registered strobes, acks and datapath.
  always_ff @(posedge hClk or negedge hReset_n) begin
    if (!hReset_n) begin
      r <= '0;
    end else if (swRst) begin
      r <= '0;
    end else begin
      r.cmd_ack      <= 1'b0;
      r.wr_ack       <= 1'b0;
      r.rd_ack       <= 1'b0;
      r.reg_wr_en    <= 1'b0;
      r.reg_rd_en    <= 1'b0;
      r.err_unmapped <= 1'b0;
      r.err_tmo      <= 1'b0;
      case (r.state)
        ST_IDLE: begin
          if (cmdIf_req && cmdIf_trEn) begin
            r.waddr   <= cmdIf_addr[11:2];
            r.wr      <= cmdIf_wrRd;
            r.region  <= decode_region(cmdIf_addr[31:12]);
            r.cmd_ack <= 1'b1;
            r.state   <= ST_ARMED;
          end
        end
        ST_ARMED, ST_ACK: begin
          if (!cmdIf_trEn) begin
            r.state <= ST_IDLE;
          end else if (beat_req) begin
            case (r.region)
              RGN_REG: begin
                r.reg_addr <= r.waddr;
                if (r.wr) begin
                  r.reg_wr_en   <= 1'b1;
                  r.reg_wr_data <= cmdIf_wrData;
                  r.wr_ack      <= 1'b1;
                  r.waddr       <= waddr_inc;
                  r.state       <= ST_ACK;
                end else begin
                  r.reg_rd_en <= 1'b1;
                  r.state     <= ST_REG_BEAT;
                end
              end
              RGN_MEM: begin
                r.mem_req     <= 1'b1;
                r.mem_wr      <= r.wr;
                r.mem_addr    <= r.waddr;
                r.mem_wr_data <= cmdIf_wrData;
                r.cnt         <= 8'd0;
                r.drain       <= 1'b0;
                r.state       <= ST_MEM_REQ;
              end
              default: begin
                // Unmapped beats complete immediately: writes dropped, reads return zero.
                r.err_unmapped <= 1'b1;
                r.waddr        <= waddr_inc;
                r.state        <= ST_ACK;
                if (r.wr) begin
                  r.wr_ack <= 1'b1;
                end else begin
                  r.rd_ack  <= 1'b1;
                  r.rd_data <= 32'h0;
                end
              end
            endcase
          end else if (cmdIf_req) begin
            r.waddr   <= cmdIf_addr[11:2];
            r.wr      <= cmdIf_wrRd;
            r.region  <= decode_region(cmdIf_addr[31:12]);
            r.cmd_ack <= 1'b1;
            r.state   <= ST_ARMED;
          end else begin
            r.state <= ST_ARMED;
          end
        end
        ST_REG_BEAT: begin
          r.rd_data <= reg_rdData;
          r.rd_ack  <= 1'b1;
          r.waddr   <= waddr_inc;
          r.state   <= ST_ACK;
        end
        ST_MEM_REQ: begin
          if (mem_gnt) begin
            r.mem_req <= 1'b0;
            r.cnt     <= cnt_inc;
            if (r.mem_wr) begin
              if (cmdIf_trEn) begin
                r.wr_ack <= 1'b1;
                r.waddr  <= waddr_inc;
                r.state  <= ST_ACK;
              end else begin
                r.state <= ST_IDLE;
              end
            end else begin
              r.drain <= ~cmdIf_trEn;
              r.state <= ST_MEM_RDWAIT;
            end
          end else if (!cmdIf_trEn) begin
            r.mem_req <= 1'b0;
            r.state   <= ST_IDLE;
          end else if (cnt_inc == TMO_MAX) begin
            r.mem_req <= 1'b0;
            r.err_tmo <= 1'b1;
            r.waddr   <= waddr_inc;
            r.state   <= ST_ACK;
            if (r.mem_wr) begin
              r.wr_ack <= 1'b1;
            end else begin
              r.rd_ack  <= 1'b1;
              r.rd_data <= 32'h0;
            end
          end else begin
            r.cnt <= cnt_inc;
          end
        end
        ST_MEM_RDWAIT: begin
          // Once the transfer is abandoned the read still has to land before going idle.
          if (!cmdIf_trEn)
            r.drain <= 1'b1;
          if (mem_rdVld) begin
            if (drain_now) begin
              r.state <= ST_IDLE;
            end else begin
              r.rd_data <= mem_rdData;
              r.rd_ack  <= 1'b1;
              r.waddr   <= waddr_inc;
              r.state   <= ST_ACK;
            end
          end else if (cnt_inc == TMO_MAX) begin
            if (drain_now) begin
              r.state <= ST_IDLE;
            end else begin
              r.err_tmo <= 1'b1;
              r.rd_ack  <= 1'b1;
              r.rd_data <= 32'h0;
              r.waddr   <= waddr_inc;
              r.state   <= ST_ACK;
            end
          end else begin
            r.cnt <= cnt_inc;
          end
        end
        default: begin
          r.state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmdIf_ack        = r.cmd_ack;
  assign cmdIf_wrData_ack = r.wr_ack;
  assign cmdIf_rdData_ack = r.rd_ack;
  assign cmdIf_rdData     = r.rd_data;
  assign reg_wrEn         = r.reg_wr_en;
  assign reg_rdEn         = r.reg_rd_en;
  assign reg_addr         = r.reg_addr;
  assign reg_wrData       = r.reg_wr_data;
  assign mem_req          = r.mem_req;
  assign mem_wr           = r.mem_wr;
  assign mem_addr         = r.mem_addr;
  assign mem_wrData       = r.mem_wr_data;
  assign err_unmapped     = r.err_unmapped;
  assign err_tmo          = r.err_tmo;

endmodule
